// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, state encoding,
// opcode classes and the fixed bit map of the ctrl strobe bundle.
package cu_pkg;

    localparam logic [4:0] OP_RALU_LAST = 5'h08;
    localparam logic [4:0] OP_IMM_FIRST = 5'h09;
    localparam logic [4:0] OP_IMM_LAST  = 5'h0B;
    localparam logic [4:0] OP_LD        = 5'h0C;
    localparam logic [4:0] OP_LDI       = 5'h0D;
    localparam logic [4:0] OP_ST        = 5'h0E;
    localparam logic [4:0] OP_MUL       = 5'h0F;
    localparam logic [4:0] OP_DIV       = 5'h10;
    localparam logic [4:0] OP_NEG       = 5'h11;
    localparam logic [4:0] OP_NOT       = 5'h12;
    localparam logic [4:0] OP_BR        = 5'h13;
    localparam logic [4:0] OP_JR        = 5'h14;
    localparam logic [4:0] OP_JAL       = 5'h15;
    localparam logic [4:0] OP_IN        = 5'h16;
    localparam logic [4:0] OP_OUT       = 5'h17;
    localparam logic [4:0] OP_MFHI      = 5'h18;
    localparam logic [4:0] OP_MFLO      = 5'h19;
    localparam logic [4:0] OP_NOP       = 5'h1A;
    localparam logic [4:0] OP_HALT      = 5'h1B;

    typedef enum logic [3:0] {
        ST_RESET, ST_FETCH0, ST_FETCH1, ST_FETCH2,
        ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_STEP_WAIT, ST_HALT
    } state_t;

    localparam int CLS_RALU = 0,  CLS_IMM = 1,  CLS_LD = 2,    CLS_LDI = 3,  CLS_ST = 4;
    localparam int CLS_MULDIV = 5, CLS_NEGNOT = 6, CLS_BR = 7, CLS_JR = 8, CLS_JAL = 9;
    localparam int CLS_IN = 10,  CLS_OUT = 11, CLS_MFHI = 12, CLS_MFLO = 13, CLS_NOP = 14;
    localparam int CLS_HALT = 15, CLS_ILLEGAL = 16, CLS_N = 17;

    localparam int B_PCOUT = 0,  B_ZLOWOUT = 1, B_ZHIGHOUT = 2, B_MDROUT = 3, B_HIOUT = 4;
    localparam int B_LOOUT = 5,  B_INPORTOUT = 6, B_COUT = 7, B_R_OUT = 8, B_BAOUT = 9;
    localparam int B_MARIN = 10, B_MDRIN = 11, B_IRIN = 12, B_YIN = 13, B_PCIN = 14;
    localparam int B_ZHIIN = 15, B_ZLOIN = 16, B_HIIN = 17, B_LOIN = 18, B_R_IN = 19;
    localparam int B_CONIN = 20, B_READ = 21, B_RAM_WR = 22, B_EN_OUTPORT = 23, B_GRA = 24;
    localparam int B_GRB = 25,   B_GRC = 26, B_INCPC = 27, B_BRANCH_FLAG = 28;
    localparam int N_STROBES = 29;

    function automatic logic [N_STROBES-1:0] sb(input int idx);
        sb = {{(N_STROBES-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Execute-step ordinal: T3 is step 1, T7 is step 5; 0 outside execute.
    function automatic logic [2:0] exec_index(input state_t s);
        case (s)
            ST_T3:   exec_index = 3'd1;
            ST_T4:   exec_index = 3'd2;
            ST_T5:   exec_index = 3'd3;
            ST_T6:   exec_index = 3'd4;
            ST_T7:   exec_index = 3'd5;
            default: exec_index = 3'd0;
        endcase
    endfunction

    function automatic state_t next_exec(input state_t s);
        case (s)
            ST_T3:   next_exec = ST_T4;
            ST_T4:   next_exec = ST_T5;
            ST_T5:   next_exec = ST_T6;
            ST_T6:   next_exec = ST_T7;
            default: next_exec = ST_FETCH0;
        endcase
    endfunction

endpackage

// File: rtl/cu_if.sv
// Control-unit <-> datapath bundle: IR/CONFF/stop/step in, strobes and status out.
interface cu_if #(parameter int CTRL_W = 32);
    logic [31:0]       ir;
    logic              con_ff;
    logic              stop;
    logic              step;
    logic [CTRL_W-1:0] ctrl;
    logic              run;
    logic              illegal;

    modport master (input ir, con_ff, stop, step, output ctrl, run, illegal);
    modport slave  (output ir, con_ff, stop, step, input ctrl, run, illegal);
endinterface

// File: rtl/cu_op_decode.sv
// Opcode to one-hot instruction class plus number of execute steps (combinational).
module cu_op_decode
    import cu_pkg::*;
(
    input  logic [4:0]       opcode,
    output logic [CLS_N-1:0] cls,
    output logic [2:0]       n_steps
);

    always_comb begin
        cls     = '0;
        n_steps = 3'd0;
        case (opcode) inside
            [5'h00:OP_RALU_LAST]:       begin cls[CLS_RALU]    = 1'b1; n_steps = 3'd3; end
            [OP_IMM_FIRST:OP_IMM_LAST]: begin cls[CLS_IMM]     = 1'b1; n_steps = 3'd3; end
            OP_LD:                      begin cls[CLS_LD]      = 1'b1; n_steps = 3'd5; end
            OP_LDI:                     begin cls[CLS_LDI]     = 1'b1; n_steps = 3'd3; end
            OP_ST:                      begin cls[CLS_ST]      = 1'b1; n_steps = 3'd5; end
            OP_MUL, OP_DIV:             begin cls[CLS_MULDIV]  = 1'b1; n_steps = 3'd4; end
            OP_NEG, OP_NOT:             begin cls[CLS_NEGNOT]  = 1'b1; n_steps = 3'd2; end
            OP_BR:                      begin cls[CLS_BR]      = 1'b1; n_steps = 3'd4; end
            OP_JR:                      begin cls[CLS_JR]      = 1'b1; n_steps = 3'd1; end
            OP_JAL:                     begin cls[CLS_JAL]     = 1'b1; n_steps = 3'd2; end
            OP_IN:                      begin cls[CLS_IN]      = 1'b1; n_steps = 3'd1; end
            OP_OUT:                     begin cls[CLS_OUT]     = 1'b1; n_steps = 3'd1; end
            OP_MFHI:                    begin cls[CLS_MFHI]    = 1'b1; n_steps = 3'd1; end
            OP_MFLO:                    begin cls[CLS_MFLO]    = 1'b1; n_steps = 3'd1; end
            OP_NOP:                     cls[CLS_NOP]     = 1'b1;
            OP_HALT:                    cls[CLS_HALT]    = 1'b1;
            default:                    cls[CLS_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired fetch/execute sequencer driving the datapath strobe bundle.
// Optional CU_SINGLE_STEP_EN: park in STEP_WAIT after every instruction until step.
module cpu_control_unit
    import cu_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CTRL_W  = 32
) (
    input logic  clk,
    input logic  clr,
    cu_if.master bus
);

`ifdef CU_SINGLE_STEP_EN
    localparam state_t INSTR_DONE = ST_STEP_WAIT;
`else
    localparam state_t INSTR_DONE = ST_FETCH0;
`endif

    state_t                 state_reg, state_next;
    logic [2:0]             wait_reg, wait_next;
    logic                   illegal_reg, illegal_next;
    logic [CLS_N-1:0]       cls;
    logic [2:0]             n_steps;
    logic [N_STROBES-1:0]   strobes;
    logic                   unused_bits;

    cu_op_decode u_op_decode (
        .opcode  (bus.ir[31:27]),
        .cls     (cls),
        .n_steps (n_steps)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg   <= ST_RESET;
            wait_reg    <= 3'd0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wait_reg    <= wait_next;
            illegal_reg <= illegal_next;
        end
    end

    // The IR is only loaded at the end of FETCH2, so the opcode is first seen in T3;
    // zero-step opcodes (nop/halt/illegal) therefore spend T3 with no strobes.
    always_comb begin
        state_next   = state_reg;
        wait_next    = wait_reg;
        illegal_next = illegal_reg;
        case (state_reg)
            ST_RESET:  state_next = ST_FETCH0;
            ST_FETCH0: begin
                state_next = ST_FETCH1;
                wait_next  = 3'(MEM_LAT);
            end
            ST_FETCH1: begin
                if (wait_reg == 3'd0) state_next = ST_FETCH2;
                else                  wait_next  = wait_reg - 3'd1;
            end
            ST_FETCH2: state_next = ST_T3;
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                if (state_reg == ST_T6 && cls[CLS_LD] && wait_reg != 3'd0) begin
                    wait_next = wait_reg - 3'd1;
                end else if (exec_index(state_reg) >= n_steps) begin
                    if (cls[CLS_ILLEGAL]) begin
                        illegal_next = 1'b1;
                        state_next   = ST_HALT;
                    end else if (cls[CLS_HALT] || bus.stop) begin
                        state_next = ST_HALT;
                    end else begin
                        state_next = INSTR_DONE;
                    end
                end else begin
                    state_next = next_exec(state_reg);
                    if (state_reg == ST_T5 && cls[CLS_LD]) wait_next = 3'(MEM_LAT);
                end
            end
`ifdef CU_SINGLE_STEP_EN
            ST_STEP_WAIT: begin
                if (bus.stop)      state_next = ST_HALT;
                else if (bus.step) state_next = ST_FETCH0;
            end
`endif
            ST_HALT: ;
            default: state_next = ST_RESET;
        endcase
    end

    always_comb begin
        strobes = '0;
        case (state_reg)
            ST_FETCH0: strobes = sb(B_PCOUT) | sb(B_MARIN) | sb(B_INCPC) | sb(B_ZLOIN);
            ST_FETCH1: strobes = sb(B_ZLOWOUT) | sb(B_PCIN) | sb(B_READ) | sb(B_MDRIN);
            ST_FETCH2: strobes = sb(B_MDROUT) | sb(B_IRIN);
            ST_T3: case (1'b1)
                cls[CLS_RALU], cls[CLS_IMM]:       strobes = sb(B_GRB) | sb(B_R_OUT) | sb(B_YIN);
                cls[CLS_LD], cls[CLS_LDI], cls[CLS_ST]:
                                                   strobes = sb(B_GRB) | sb(B_BAOUT) | sb(B_YIN);
                cls[CLS_MULDIV]:                   strobes = sb(B_GRA) | sb(B_R_OUT) | sb(B_YIN);
                cls[CLS_NEGNOT]:                   strobes = sb(B_GRB) | sb(B_R_OUT) | sb(B_ZLOIN);
                cls[CLS_BR]:                       strobes = sb(B_GRA) | sb(B_R_OUT) | sb(B_CONIN);
                cls[CLS_JR]:                       strobes = sb(B_GRA) | sb(B_R_OUT) | sb(B_PCIN);
                cls[CLS_JAL]:                      strobes = sb(B_PCOUT) | sb(B_GRB) | sb(B_R_IN);
                cls[CLS_IN]:                       strobes = sb(B_INPORTOUT) | sb(B_GRA) | sb(B_R_IN);
                cls[CLS_OUT]:                      strobes = sb(B_GRA) | sb(B_R_OUT) | sb(B_EN_OUTPORT);
                cls[CLS_MFHI]:                     strobes = sb(B_HIOUT) | sb(B_GRA) | sb(B_R_IN);
                cls[CLS_MFLO]:                     strobes = sb(B_LOOUT) | sb(B_GRA) | sb(B_R_IN);
                default: ;
            endcase
            ST_T4: case (1'b1)
                cls[CLS_RALU]:                     strobes = sb(B_GRC) | sb(B_R_OUT) | sb(B_ZLOIN);
                cls[CLS_IMM], cls[CLS_LD], cls[CLS_LDI], cls[CLS_ST]:
                                                   strobes = sb(B_COUT) | sb(B_ZLOIN);
                cls[CLS_MULDIV]:  strobes = sb(B_GRB) | sb(B_R_OUT) | sb(B_ZHIIN) | sb(B_ZLOIN);
                cls[CLS_NEGNOT]:                   strobes = sb(B_ZLOWOUT) | sb(B_GRA) | sb(B_R_IN);
                cls[CLS_BR]:                       strobes = sb(B_PCOUT) | sb(B_YIN);
                cls[CLS_JAL]:                      strobes = sb(B_GRA) | sb(B_R_OUT) | sb(B_PCIN);
                default: ;
            endcase
            ST_T5: case (1'b1)
                cls[CLS_RALU], cls[CLS_IMM], cls[CLS_LDI]:
                                                   strobes = sb(B_ZLOWOUT) | sb(B_GRA) | sb(B_R_IN);
                cls[CLS_LD], cls[CLS_ST]:          strobes = sb(B_ZLOWOUT) | sb(B_MARIN);
                cls[CLS_MULDIV]:                   strobes = sb(B_ZLOWOUT) | sb(B_LOIN);
                cls[CLS_BR]:                       strobes = sb(B_COUT) | sb(B_BRANCH_FLAG) | sb(B_ZLOIN);
                default: ;
            endcase
            ST_T6: case (1'b1)
                cls[CLS_LD]:                       strobes = sb(B_READ) | sb(B_MDRIN);
                cls[CLS_ST]:                       strobes = sb(B_GRA) | sb(B_R_OUT) | sb(B_MDRIN);
                cls[CLS_MULDIV]:                   strobes = sb(B_ZHIGHOUT) | sb(B_HIIN);
                cls[CLS_BR]:      strobes = sb(B_ZLOWOUT) | (bus.con_ff ? sb(B_PCIN) : '0);
                default: ;
            endcase
            ST_T7: case (1'b1)
                cls[CLS_LD]:                       strobes = sb(B_MDROUT) | sb(B_GRA) | sb(B_R_IN);
                cls[CLS_ST]:                       strobes = sb(B_RAM_WR);
                default: ;
            endcase
            default: ;
        endcase
    end

    assign bus.ctrl[N_STROBES-1:0] = strobes;

    genvar gi;
    generate
        for (gi = N_STROBES; gi < CTRL_W; gi++) begin : g_spare_ctrl
            assign bus.ctrl[gi] = 1'b0;
        end
    endgenerate

    assign bus.run     = (state_reg != ST_RESET) && (state_reg != ST_HALT);
    assign bus.illegal = illegal_reg;

`ifdef CU_SINGLE_STEP_EN
    assign unused_bits = ^{bus.ir[26:0], cls[CLS_NOP]};
`else
    assign unused_bits = ^{bus.ir[26:0], cls[CLS_NOP], bus.step};
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: vector table, abort/stop sequences and
// random instruction streams against a per-opcode strobe-list model.
module tb_cpu_control_unit;
    import cu_pkg::*;

    localparam int MEM_LAT = 2;

    typedef struct {
        logic [4:0] op;
        logic       cf;
        int         cycles;
        int         stop_at;
        int         abort_at;
        logic       halts;
        logic       ill;
    } vec_t;

    logic clk = 1'b0;
    logic clr;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[24];

    cu_if #(.CTRL_W(32)) bus();

    cpu_control_unit #(.MEM_LAT(MEM_LAT), .CTRL_W(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] w(input int idx);
        return 32'd1 << idx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference: the full strobe list of one instruction, fetch through last execute step.
    task automatic build_expected(input logic [4:0] op, input logic cf);
        logic [31:0] ld_head[3];
        ld_head[0] = w(B_GRB) | w(B_BAOUT) | w(B_YIN);
        ld_head[1] = w(B_COUT) | w(B_ZLOIN);
        ld_head[2] = w(B_ZLOWOUT) | w(B_MARIN);
        exp_q.delete();
        exp_q.push_back(w(B_PCOUT) | w(B_MARIN) | w(B_INCPC) | w(B_ZLOIN));
        for (int k = 0; k <= MEM_LAT; k++)
            exp_q.push_back(w(B_ZLOWOUT) | w(B_PCIN) | w(B_READ) | w(B_MDRIN));
        exp_q.push_back(w(B_MDROUT) | w(B_IRIN));
        if (op <= 5'h0B) begin
            exp_q.push_back(w(B_GRB) | w(B_R_OUT) | w(B_YIN));
            exp_q.push_back(op <= 5'h08 ? (w(B_GRC) | w(B_R_OUT) | w(B_ZLOIN)) : (w(B_COUT) | w(B_ZLOIN)));
            exp_q.push_back(w(B_ZLOWOUT) | w(B_GRA) | w(B_R_IN));
        end else if (op == 5'h0C) begin
            for (int k = 0; k < 3; k++) exp_q.push_back(ld_head[k]);
            for (int k = 0; k <= MEM_LAT; k++) exp_q.push_back(w(B_READ) | w(B_MDRIN));
            exp_q.push_back(w(B_MDROUT) | w(B_GRA) | w(B_R_IN));
        end else if (op == 5'h0D) begin
            for (int k = 0; k < 2; k++) exp_q.push_back(ld_head[k]);
            exp_q.push_back(w(B_ZLOWOUT) | w(B_GRA) | w(B_R_IN));
        end else if (op == 5'h0E) begin
            for (int k = 0; k < 3; k++) exp_q.push_back(ld_head[k]);
            exp_q.push_back(w(B_GRA) | w(B_R_OUT) | w(B_MDRIN));
            exp_q.push_back(w(B_RAM_WR));
        end else if (op == 5'h0F || op == 5'h10) begin
            exp_q.push_back(w(B_GRA) | w(B_R_OUT) | w(B_YIN));
            exp_q.push_back(w(B_GRB) | w(B_R_OUT) | w(B_ZHIIN) | w(B_ZLOIN));
            exp_q.push_back(w(B_ZLOWOUT) | w(B_LOIN));
            exp_q.push_back(w(B_ZHIGHOUT) | w(B_HIIN));
        end else if (op == 5'h11 || op == 5'h12) begin
            exp_q.push_back(w(B_GRB) | w(B_R_OUT) | w(B_ZLOIN));
            exp_q.push_back(w(B_ZLOWOUT) | w(B_GRA) | w(B_R_IN));
        end else if (op == 5'h13) begin
            exp_q.push_back(w(B_GRA) | w(B_R_OUT) | w(B_CONIN));
            exp_q.push_back(w(B_PCOUT) | w(B_YIN));
            exp_q.push_back(w(B_COUT) | w(B_BRANCH_FLAG) | w(B_ZLOIN));
            exp_q.push_back(w(B_ZLOWOUT) | (cf ? w(B_PCIN) : 32'd0));
        end else if (op == 5'h14) exp_q.push_back(w(B_GRA) | w(B_R_OUT) | w(B_PCIN));
        else if (op == 5'h15) begin
            exp_q.push_back(w(B_PCOUT) | w(B_GRB) | w(B_R_IN));
            exp_q.push_back(w(B_GRA) | w(B_R_OUT) | w(B_PCIN));
        end
        else if (op == 5'h16) exp_q.push_back(w(B_INPORTOUT) | w(B_GRA) | w(B_R_IN));
        else if (op == 5'h17) exp_q.push_back(w(B_GRA) | w(B_R_OUT) | w(B_EN_OUTPORT));
        else if (op == 5'h18) exp_q.push_back(w(B_HIOUT) | w(B_GRA) | w(B_R_IN));
        else if (op == 5'h19) exp_q.push_back(w(B_LOOUT) | w(B_GRA) | w(B_R_IN));
        else exp_q.push_back(32'd0);  // nop/halt/illegal: decode cycle only
    endtask

    task automatic do_reset();
        clr = 1'b1;
        bus.stop = 1'b0;
        bus.step = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", bus.ctrl, 32'd0);
        chk("reset_run", {31'd0, bus.run}, 32'd0);
        chk("reset_illegal", {31'd0, bus.illegal}, 32'd0);
        clr = 1'b0;
    endtask

    // Entered one negedge before FETCH0 is expected.
    task automatic run_instr(input logic [4:0] op, input logic cf, input int cycles,
                             input int stop_at, input int abort_at,
                             input logic halts, input logic ill);
        logic [26:0] low;
        logic [31:0] exp_w;
        int n;
        build_expected(op, cf);
        n = (cycles < 0) ? exp_q.size() : cycles;
        $display("instr op=%02h con_ff=%0d cycles=%0d stop_at=%0d abort_at=%0d", op, cf, n, stop_at, abort_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_w = (i < exp_q.size()) ? exp_q[i] : 32'hFFFF_FFFF;
            chk($sformatf("ctrl op%02h c%0d", op, i), bus.ctrl, exp_w);
            chk($sformatf("run op%02h c%0d", op, i), {31'd0, bus.run}, 32'd1);
            chk($sformatf("illegal op%02h c%0d", op, i), {31'd0, bus.illegal}, 32'd0);
            if (i == 0) begin
                low = 27'($urandom());
                bus.ir = {op, low};
                bus.con_ff = cf;
            end
            if (i == stop_at) bus.stop = 1'b1;
            if (i == abort_at) begin
                clr = 1'b1;
                @(negedge clk);
                chk("abort_ctrl", bus.ctrl, 32'd0);
                chk("abort_run", {31'd0, bus.run}, 32'd0);
                clr = 1'b0;
                bus.stop = 1'b0;
                return;
            end
        end
        if (halts) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                chk($sformatf("halt_ctrl op%02h", op), bus.ctrl, 32'd0);
                chk($sformatf("halt_run op%02h", op), {31'd0, bus.run}, 32'd0);
                chk($sformatf("halt_illegal op%02h", op), {31'd0, bus.illegal}, {31'd0, ill});
                bus.stop = 1'b0;
            end
            do_reset();
        end else begin
`ifdef CU_SINGLE_STEP_EN
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                chk("step_wait_ctrl", bus.ctrl, 32'd0);
                chk("step_wait_run", {31'd0, bus.run}, 32'd1);
            end
            bus.step = 1'b1;
            @(posedge clk);
            #1 bus.step = 1'b0;
`endif
        end
    endtask

    initial begin
        bus.ir = 32'd0;
        bus.con_ff = 1'b0;
        bus.stop = 1'b0;
        bus.step = 1'b0;
        clr = 1'b1;

        vecs[0]  = '{5'h00, 1'b0,  8, -1, -1, 1'b0, 1'b0};
        vecs[1]  = '{5'h0A, 1'b0,  8, -1, -1, 1'b0, 1'b0};
        vecs[2]  = '{5'h13, 1'b0,  9, -1, -1, 1'b0, 1'b0};
        vecs[3]  = '{5'h13, 1'b1,  9, -1, -1, 1'b0, 1'b0};
        vecs[4]  = '{5'h0E, 1'b0, 10, -1, -1, 1'b0, 1'b0};
        vecs[5]  = '{5'h0C, 1'b0, 12, -1, -1, 1'b0, 1'b0};
        vecs[6]  = '{5'h0D, 1'b0,  8, -1, -1, 1'b0, 1'b0};
        vecs[7]  = '{5'h0F, 1'b0,  9,  6, -1, 1'b1, 1'b0};
        vecs[8]  = '{5'h10, 1'b1,  9, -1, -1, 1'b0, 1'b0};
        vecs[9]  = '{5'h11, 1'b0,  7, -1, -1, 1'b0, 1'b0};
        vecs[10] = '{5'h12, 1'b0,  7, -1, -1, 1'b0, 1'b0};
        vecs[11] = '{5'h14, 1'b0,  6, -1, -1, 1'b0, 1'b0};
        vecs[12] = '{5'h15, 1'b0,  7, -1, -1, 1'b0, 1'b0};
        vecs[13] = '{5'h16, 1'b0,  6, -1, -1, 1'b0, 1'b0};
        vecs[14] = '{5'h17, 1'b0,  6, -1, -1, 1'b0, 1'b0};
        vecs[15] = '{5'h18, 1'b0,  6, -1, -1, 1'b0, 1'b0};
        vecs[16] = '{5'h19, 1'b0,  6, -1, -1, 1'b0, 1'b0};
        vecs[17] = '{5'h1A, 1'b0,  6, -1, -1, 1'b0, 1'b0};
        vecs[18] = '{5'h0C, 1'b0, 12, -1,  7, 1'b0, 1'b0};
        vecs[19] = '{5'h1B, 1'b0,  6, -1, -1, 1'b1, 1'b0};
        vecs[20] = '{5'h1E, 1'b0,  6, -1, -1, 1'b1, 1'b1};
        vecs[21] = '{5'h08, 1'b0,  8, -1, -1, 1'b0, 1'b0};
        vecs[22] = '{5'h0B, 1'b0,  8, -1, -1, 1'b0, 1'b0};
        vecs[23] = '{5'h1C, 1'b1,  6, -1, -1, 1'b1, 1'b1};

        do_reset();
        for (int v = 0; v < 24; v++)
            run_instr(vecs[v].op, vecs[v].cf, vecs[v].cycles, vecs[v].stop_at,
                      vecs[v].abort_at, vecs[v].halts, vecs[v].ill);

        for (int r = 0; r < 40; r++) begin
            logic [4:0] rop;
            logic       rcf;
            rop = 5'($urandom_range(0, 26));
            rcf = 1'($urandom_range(0, 1));
            run_instr(rop, rcf, -1, -1, -1, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
